// File: rtl/hist_eq_pkg.sv
// Shared types for the histogram-equalization frame sequencer: FSM states and err_flags bit positions.
package hist_eq_pkg;

  typedef enum logic [2:0] {
    SEEK_SOF   = 3'd0,
    ACTIVE     = 3'd1,
    CDF        = 3'd2,
    SWAP       = 3'd3,
    CLEAR      = 3'd4,
    RESYNC_CLR = 3'd5
  } state_e;

  localparam int ERR_EARLY_TLAST = 0;
  localparam int ERR_MISS_TLAST  = 1;
  localparam int ERR_UNEXP_TUSER = 2;
  localparam int ERR_CDF_TO      = 3;

endpackage

// File: rtl/hist_eq_pos_counter.sv
// Pixel/line position tracker with wrap; flags end-of-line and end-of-frame for the current beat.
module hist_eq_pos_counter #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 1024,
  parameter int CW     = 13
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start_i,
  input  logic adv_i,
  output logic eol_o,
  output logic eof_o
);

  localparam logic [CW-1:0] PX_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LN_LAST = CW'(HEIGHT - 1);

  logic [CW-1:0] px_q;
  logic [CW-1:0] ln_q;

  assign eol_o = (px_q == PX_LAST);
  assign eof_o = eol_o && (ln_q == LN_LAST);

  // start_i counts the SOF beat itself, so the next beat is pixel 1.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      px_q <= '0;
      ln_q <= '0;
    end else if (start_i) begin
      px_q <= CW'(1);
      ln_q <= '0;
    end else if (adv_i) begin
      if (eol_o) begin
        px_q <= '0;
        ln_q <= eof_o ? '0 : ln_q + 1'b1;
      end else begin
        px_q <= px_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hist_eq_frame_ctrl.sv
// Frame sequencer for histogram equalization: validates tuser/tlast, forwards pixels, drives
// accumulate/CDF/swap/clear phases. Optional CDF watchdog enabled by HIST_EQ_CDF_TIMEOUT_EN.
module hist_eq_frame_ctrl
  import hist_eq_pkg::*;
#(
  parameter int N      = 8,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 1024,
  parameter int CW     = 13
`ifdef HIST_EQ_CDF_TIMEOUT_EN
  , parameter int CDF_TIMEOUT = 4096
`endif
) (
  input  logic         sys_clk,
  input  logic         sys_aresetn,
  input  logic [N-1:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  input  logic         s_axis_tuser,
  output logic [N-1:0] m_axis_tdata,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         m_axis_tlast,
  output logic         m_axis_tuser,
  output logic         hist_wr_en,
  output logic [N-1:0] hist_wr_data,
  output logic         cdf_start,
  input  logic         cdf_done,
  output logic         lut_swap,
  output logic         hist_clr,
  output logic [3:0]   err_flags,
  input  logic         err_clr,
  output logic [15:0]  frame_cnt
);

  state_e         state_q, state_d;
  logic [N-1:0]   clr_cnt_q, clr_cnt_d;
  logic           run_q;
  logic           cdf_wait_q;
  logic           frame_bad_q;
  logic [3:0]     err_q;
  logic [15:0]    frame_cnt_q;
  logic [N-1:0]   m_tdata_q;
  logic           m_tvalid_q, m_tlast_q, m_tuser_q;
  logic           hist_wr_en_q;
  logic [N-1:0]   hist_wr_data_q;
  logic [N-1:0]   hold_q;

  logic           accept, eol, eof;
  logic           fwd, fwd_last, fwd_user;
  logic           pos_start, pos_adv;
  logic           acc_hist, hold_load, hist_release;
  logic           bad_set, bad_clr;
  logic [3:0]     err_set;

`ifdef HIST_EQ_CDF_TIMEOUT_EN
  localparam int           TW      = $clog2(CDF_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(CDF_TIMEOUT - 1);
  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge sys_clk or negedge sys_aresetn) begin
    if (!sys_aresetn) to_cnt_q <= '0;
    else              to_cnt_q <= (state_q == CDF) ? to_cnt_q + 1'b1 : '0;
  end

  assign err_flags = err_q;
`else
  assign err_flags = err_q & ~(4'b0001 << ERR_CDF_TO);
`endif

  hist_eq_pos_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .CW     (CW)
  ) u_pos (
    .clk_i   (sys_clk),
    .rst_n_i (sys_aresetn),
    .start_i (pos_start),
    .adv_i   (pos_adv),
    .eol_o   (eol),
    .eof_o   (eof)
  );

  assign s_axis_tready = run_q && ((state_q == SEEK_SOF) || (state_q == ACTIVE)) &&
                         (!m_tvalid_q || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign hist_wr_en    = hist_wr_en_q;
  assign hist_wr_data  = hist_wr_data_q;
  assign frame_cnt     = frame_cnt_q;
  // cdf_wait_q is low only on the CDF entry cycle, giving the one-cycle start pulse.
  assign cdf_start     = (state_q == CDF) && !cdf_wait_q;
  assign lut_swap      = (state_q == SWAP);
  assign hist_clr      = (state_q == CLEAR) || (state_q == RESYNC_CLR);

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    fwd          = 1'b0;
    fwd_last     = 1'b0;
    fwd_user     = 1'b0;
    pos_start    = 1'b0;
    pos_adv      = 1'b0;
    acc_hist     = 1'b0;
    hold_load    = 1'b0;
    hist_release = 1'b0;
    bad_set      = 1'b0;
    bad_clr      = 1'b0;
    err_set      = '0;
    case (state_q)
      SEEK_SOF: begin
        if (accept && s_axis_tuser) begin
          fwd       = 1'b1;
          fwd_user  = 1'b1;
          pos_start = 1'b1;
          acc_hist  = 1'b1;
          state_d   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept) begin
          fwd = 1'b1;
          if (s_axis_tuser) begin
            // The new SOF beat waits in hold_q until the old histogram is wiped.
            err_set[ERR_UNEXP_TUSER] = 1'b1;
            bad_set   = 1'b1;
            fwd_user  = 1'b1;
            pos_start = 1'b1;
            hold_load = 1'b1;
            state_d   = RESYNC_CLR;
          end else begin
            acc_hist = 1'b1;
            pos_adv  = 1'b1;
            if (eol) begin
              fwd_last = 1'b1;
              if (!s_axis_tlast) err_set[ERR_MISS_TLAST] = 1'b1;
              if (eof) state_d = frame_bad_q ? CLEAR : CDF;
            end else if (s_axis_tlast) begin
              err_set[ERR_EARLY_TLAST] = 1'b1;
              bad_set  = 1'b1;
              fwd_last = 1'b1;
              state_d  = CLEAR;
            end
          end
        end
      end
      CDF: begin
`ifdef HIST_EQ_CDF_TIMEOUT_EN
        if (cdf_wait_q && cdf_done) begin
          state_d = SWAP;
        end else if (to_cnt_q == TO_LAST) begin
          err_set[ERR_CDF_TO] = 1'b1;
          state_d = CLEAR;
        end
`else
        if (cdf_wait_q && cdf_done) state_d = SWAP;
`endif
      end
      SWAP: state_d = CLEAR;
      CLEAR, RESYNC_CLR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          if (state_q == CLEAR) begin
            state_d = SEEK_SOF;
            bad_clr = 1'b1;
          end else begin
            state_d      = ACTIVE;
            hist_release = 1'b1;
          end
        end
      end
      default: state_d = SEEK_SOF;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_aresetn) begin
    if (!sys_aresetn) begin
      state_q        <= SEEK_SOF;
      clr_cnt_q      <= '0;
      run_q          <= 1'b0;
      cdf_wait_q     <= 1'b0;
      frame_bad_q    <= 1'b0;
      err_q          <= '0;
      frame_cnt_q    <= '0;
      m_tdata_q      <= '0;
      m_tvalid_q     <= 1'b0;
      m_tlast_q      <= 1'b0;
      m_tuser_q      <= 1'b0;
      hist_wr_en_q   <= 1'b0;
      hist_wr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      run_q       <= 1'b1;
      cdf_wait_q  <= (state_q == CDF);
      if (bad_set)      frame_bad_q <= 1'b1;
      else if (bad_clr) frame_bad_q <= 1'b0;
      err_q <= (err_clr ? 4'b0000 : err_q) | err_set;
      if (state_q == SWAP) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (fwd) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= s_axis_tdata;
        m_tlast_q  <= fwd_last;
        m_tuser_q  <= fwd_user;
      end else if (m_axis_tready) begin
        m_tvalid_q <= 1'b0;
      end
      hist_wr_en_q <= acc_hist || hist_release;
      if (hist_release)  hist_wr_data_q <= hold_q;
      else if (acc_hist) hist_wr_data_q <= s_axis_tdata;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (hold_load) hold_q <= s_axis_tdata;
  end

endmodule

// File: tb/tb_hist_eq_frame_ctrl.sv
// Directed bench for hist_eq_frame_ctrl on a 10x10 frame: scenario table plus resync/timeout/reset sequences.
module tb_hist_eq_frame_ctrl;
  localparam int W = 10;
  localparam int H = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tlast, m_tuser;
  logic       m_tready;
  logic       hist_wr_en, cdf_start, lut_swap, hist_clr, err_clr = 1'b0;
  logic [7:0] hist_wr_data;
  logic       cdf_done;
  logic [3:0] err_flags;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  hist_eq_frame_ctrl #(
    .N(8), .WIDTH(W), .HEIGHT(H), .CW(13)
`ifdef HIST_EQ_CDF_TIMEOUT_EN
    , .CDF_TIMEOUT(16)
`endif
  ) dut (
    .sys_clk(clk), .sys_aresetn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .hist_wr_en(hist_wr_en), .hist_wr_data(hist_wr_data),
    .cdf_start(cdf_start), .cdf_done(cdf_done), .lut_swap(lut_swap), .hist_clr(hist_clr),
    .err_flags(err_flags), .err_clr(err_clr), .frame_cnt(frame_cnt)
  );

  function automatic logic [7:0] pix(input int i);
    return 8'(i * 37 + 5);
  endfunction

  int checks = 0, failures = 0;
  int beats = 0, tusers = 0, data_err = 0, last_err = 0, stall_err = 0, rdy_err = 0;
  int cdf_cnt = 0, swap_cnt = 0, clr_cnt = 0, wr_cnt = 0, wr_sum = 0, mon_idx = 0;
  int early_idx = -1;
  bit rnd_rdy = 1'b0;
  bit cdf_auto = 1'b1;
  logic prev_stall = 1'b0;
  logic [7:0] p_data;
  logic p_last, p_user;

  // Passive monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_tvalid && m_tready) begin
        beats++;
        if (m_tuser) begin
          tusers++;
          mon_idx = 0;
        end
        if (m_tdata != pix(mon_idx)) data_err++;
        if (m_tlast != (((mon_idx % W) == W - 1) || (mon_idx == early_idx))) last_err++;
        mon_idx++;
      end
      if (prev_stall && (!m_tvalid || m_tdata != p_data || m_tlast != p_last || m_tuser != p_user))
        stall_err++;
      prev_stall = m_tvalid && !m_tready;
      p_data = m_tdata; p_last = m_tlast; p_user = m_tuser;
      if (cdf_start) cdf_cnt++;
      if (lut_swap) swap_cnt++;
      if (hist_clr) clr_cnt++;
      if (hist_clr && s_tready) rdy_err++;
      if (hist_wr_en) begin
        wr_cnt++;
        wr_sum += int'(hist_wr_data);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // CDF engine model: one-cycle done pulse 5 cycles after cdf_start.
  initial begin
    cdf_done = 1'b0;
    forever begin
      @(negedge clk);
      if (cdf_start && cdf_auto) begin
        repeat (5) @(posedge clk);
        #1 cdf_done = 1'b1;
        @(posedge clk);
        #1 cdf_done = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int sid, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0d want=%0d", nm, sid, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    bit ok = 1'b0;
    s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL beat_accept got=timeout want=accepted");
    end
  endtask

  task automatic send_frame(input int junk, input int drop_idx, input int eidx, input int nb);
    for (int j = 0; j < junk; j++) send_beat(8'hAA, 1'(j % 2), 1'b0);
    for (int i = 0; i < nb; i++)
      send_beat(pix(i), (((i % W) == W - 1) && (i != drop_idx)) || (i == eidx), i == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  function automatic int psum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(pix(i));
    return s;
  endfunction

  int b0, t0, c0, s0, k0, w0, u0, f0, de0, le0;

  task automatic snap();
    b0 = beats; t0 = tusers; c0 = cdf_cnt; s0 = swap_cnt; k0 = clr_cnt;
    w0 = wr_cnt; u0 = wr_sum; f0 = int'(frame_cnt); de0 = data_err; le0 = last_err;
  endtask

  task automatic verify(input int sid, input int eb, input int et, input int ec, input int es,
                        input int ek, input int ef, input logic [3:0] ee, input int esum);
    chk("beats_fwd", sid, beats - b0, eb);
    chk("tuser_beats", sid, tusers - t0, et);
    chk("cdf_start_pulses", sid, cdf_cnt - c0, ec);
    chk("lut_swap_pulses", sid, swap_cnt - s0, es);
    chk("hist_clr_cycles", sid, clr_cnt - k0, ek);
    chk("hist_wr_count", sid, wr_cnt - w0, eb);
    chk("hist_wr_sum", sid, wr_sum - u0, esum);
    chk("frame_cnt_delta", sid, int'(frame_cnt) - f0, ef);
    chk("err_flags", sid, {28'd0, err_flags}, {28'd0, ee});
    chk("data_errors", sid, data_err - de0, 0);
    chk("tlast_errors", sid, last_err - le0, 0);
  endtask

  typedef struct {
    int         junk;
    int         drop_idx;
    int         early_idx;
    bit         rnd;
    int         exp_beats;
    int         exp_cdf;
    int         exp_swap;
    int         exp_fcnt;
    logic [3:0] exp_err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{junk: 0, drop_idx: -1, early_idx: -1, rnd: 1'b0, exp_beats: 100, exp_cdf: 1, exp_swap: 1, exp_fcnt: 1, exp_err: 4'b0000};
    tbl[1] = '{junk: 7, drop_idx: -1, early_idx: -1, rnd: 1'b0, exp_beats: 100, exp_cdf: 1, exp_swap: 1, exp_fcnt: 1, exp_err: 4'b0000};
    tbl[2] = '{junk: 0, drop_idx: 9,  early_idx: -1, rnd: 1'b0, exp_beats: 100, exp_cdf: 1, exp_swap: 1, exp_fcnt: 1, exp_err: 4'b0010};
    tbl[3] = '{junk: 0, drop_idx: -1, early_idx: 2,  rnd: 1'b0, exp_beats: 3,   exp_cdf: 0, exp_swap: 0, exp_fcnt: 0, exp_err: 4'b0001};
    tbl[4] = '{junk: 0, drop_idx: -1, early_idx: -1, rnd: 1'b1, exp_beats: 100, exp_cdf: 1, exp_swap: 1, exp_fcnt: 1, exp_err: 4'b0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 0, m_tvalid, 0);
    chk("rst_m_tdata", 0, m_tdata, 0);
    chk("rst_m_tlast", 0, m_tlast, 0);
    chk("rst_m_tuser", 0, m_tuser, 0);
    chk("rst_s_tready", 0, s_tready, 0);
    chk("rst_hist_wr_en", 0, hist_wr_en, 0);
    chk("rst_cdf_start", 0, cdf_start, 0);
    chk("rst_lut_swap", 0, lut_swap, 0);
    chk("rst_hist_clr", 0, hist_clr, 0);
    chk("rst_err_flags", 0, err_flags, 0);
    chk("rst_frame_cnt", 0, frame_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    for (int k = 0; k < 5; k++) begin
      early_idx = tbl[k].early_idx;
      rnd_rdy   = tbl[k].rnd;
      snap();
      send_frame(tbl[k].junk, tbl[k].drop_idx, tbl[k].early_idx,
                 (tbl[k].early_idx >= 0) ? tbl[k].early_idx + 1 : W * H);
      idle(400);
      rnd_rdy = 1'b0;
      idle(2);
      verify(k, tbl[k].exp_beats, 1, tbl[k].exp_cdf, tbl[k].exp_swap, 256,
             tbl[k].exp_fcnt, tbl[k].exp_err, psum(tbl[k].exp_beats));
      pulse_err_clr();
      chk("err_after_clr", k, err_flags, 0);
    end

    // Unexpected tuser at pixel 5 of line 0: resync clear, then the new frame is discarded.
    early_idx = -1;
    snap();
    for (int i = 0; i < 5; i++) send_beat(pix(i), 1'b0, i == 0);
    send_frame(0, -1, -1, W * H);
    idle(400);
    verify(10, 105, 2, 0, 0, 512, 0, 4'b0100, psum(5) + psum(100));
    pulse_err_clr();
    chk("err_after_clr", 10, err_flags, 0);

`ifdef HIST_EQ_CDF_TIMEOUT_EN
    cdf_auto = 1'b0;
    snap();
    send_frame(0, -1, -1, W * H);
    idle(400);
    verify(11, 100, 1, 1, 0, 256, 0, 4'b1000, psum(100));
    pulse_err_clr();
    chk("err_after_clr", 11, err_flags, 0);
    cdf_auto = 1'b1;
`endif

    // Reset in the middle of a frame.
    for (int i = 0; i < 20; i++) send_beat(pix(i), (i % W) == W - 1, i == 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_m_tvalid", 12, m_tvalid, 0);
    chk("midrst_s_tready", 12, s_tready, 0);
    chk("midrst_hist_wr_en", 12, hist_wr_en, 0);
    chk("midrst_frame_cnt", 12, frame_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);
    chk("post_rst_s_tready", 12, s_tready, 1);

    chk("stall_stability", 0, stall_err, 0);
    chk("ready_during_clr", 0, rdy_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hist_eq_frame_ctrl.md
Name: hist_eq_frame_ctrl

Overview:
Frame-level sequencer for the histogram-equalization pipeline. Sits between the AXI4-Stream video source and the histogram/LUT datapath. It validates frame structure (tuser/tlast position) and forwards in-frame pixels with regenerated tuser/tlast. It also drives accumulate, CDF-compute, LUT-swap and histogram-clear phases once per frame, recovering from dropped or early sideband beats.

Parameters:
N, 8, pixel data width
WIDTH, 1280, pixels per line
HEIGHT, 1024, lines per frame
CW, 13, pixel/line counter width; must hold max(WIDTH,HEIGHT)
CDF_TIMEOUT, 4096, max cycles to wait for cdf_done (optional feature only)

Ports:
sys_clk  in  1  clock
sys_aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  N  input pixel
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  end of line
s_axis_tuser  in  1  start of frame
m_axis_tdata  out  N  forwarded pixel
m_axis_tvalid  out  1  forwarded valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  regenerated end of line
m_axis_tuser  out  1  regenerated start of frame
hist_wr_en  out  1  accumulate strobe to histogram
hist_wr_data  out  N  pixel to accumulate
cdf_start  out  1  one-cycle pulse: compute CDF/LUT
cdf_done  in  1  CDF engine completion, level or pulse
lut_swap  out  1  one-cycle pulse: swap LUT banks
hist_clr  out  1  high while histogram is cleared
err_flags  out  4  sticky: [0] early tlast, [1] missing tlast, [2] unexpected tuser, [3] CDF timeout
err_clr  in  1  clears err_flags
frame_cnt  out  16  good frames completed, wraps at 2^16

Behaviour:
- Reset: all outputs 0, s_axis_tready 0, state SEEK_SOF, counters 0, frame_bad 0.
- Accept is s_axis_tvalid & s_axis_tready. s_axis_tready = (state is SEEK_SOF or ACTIVE) & (~m_axis_tvalid | m_axis_tready).
- Output slice is one register stage. m_axis holds its values while m_axis_tvalid & ~m_axis_tready. Latency is 1 cycle, accept to m_axis_tvalid.
- hist_wr_en/hist_wr_data: registered, 1 cycle after an in-frame accept. Independent of m_axis_tready.
- SEEK_SOF: accepted beats with tuser=0 are discarded (not forwarded, not accumulated). An accept with tuser=1 starts the frame: px=1, ln=0, pixel forwarded with m_axis_tuser=1, state becomes ACTIVE.
- ACTIVE, per accepted beat:
  - px increments. At px==WIDTH-1 the beat gets m_axis_tlast=1, px wraps to 0 and ln increments.
  - tlast=0 at px==WIDTH-1: set err[1]. Line still ends (tlast regenerated).
  - tlast=1 at px<WIDTH-1: set err[0] and frame_bad. The beat is forwarded with m_axis_tlast=1. Go to CLEAR.
  - tuser=1: set err[2] and frame_bad. Treat the beat as a new SOF: px=1, ln=0, m_axis_tuser=1, histogram cleared first (see below).
  - Last pixel (px==WIDTH-1, ln==HEIGHT-1): go to CDF if frame_bad=0, else CLEAR.
- Unexpected tuser: hist_clr asserts for 2^N cycles with s_axis_tready=0. The SOF beat is held in the slice and is accumulated only after the clear.
- CDF: cdf_start pulses on the entry cycle. Wait for cdf_done, then go to SWAP.
- SWAP: lut_swap pulses for 1 cycle. frame_cnt increments. Go to CLEAR.
- CLEAR: hist_clr=1 for exactly 2^N cycles (bin-address counter). Then frame_bad=0 and state returns to SEEK_SOF.
- err_flags are sticky. err_clr clears them; a new error in the same cycle wins.
- cdf_done arriving outside the CDF state is ignored.
- Reset mid-frame: immediate return to reset values. The partial histogram is not cleared by this block.

Optional Feature:
HIST_EQ_CDF_TIMEOUT_EN:
- Defined: a counter runs in CDF. After CDF_TIMEOUT cycles without cdf_done, set err[3] and go to CLEAR, skipping SWAP; frame_cnt does not increment.
- Undefined: CDF waits indefinitely and err[3] is tied 0.

Decomposition:
- hist_eq_pkg holds:
  - state enum (SEEK_SOF, ACTIVE, CDF, SWAP, CLEAR, RESYNC_CLR)
  - error-bit index localparams ERR_EARLY_TLAST=0, ERR_MISS_TLAST=1, ERR_UNEXP_TUSER=2, ERR_CDF_TO=3
- Sub-module hist_eq_pos_counter holds the px/ln counters with wrap and end-of-line/end-of-frame flags, reused by the LUT-apply stage.

Test Plan:
- WIDTH=10, HEIGHT=10, clean frame, m_axis_tready=1, cdf_done 5 cycles after cdf_start -> 100 beats forwarded, tlast on beats 10,20..100, one cdf_start, one lut_swap, hist_clr high 256 cycles, frame_cnt=1, err_flags=0.
- 7 junk beats before SOF -> none forwarded and hist_wr_en never asserted for them; the frame then completes normally.
- tlast dropped at px 9, line 0 -> m_axis_tlast still 1 on beat 10, err_flags=4'b0010, frame completes and lut_swap pulses.
- tlast at px 2, line 0 -> err_flags[0]=1, no cdf_start, hist_clr 256 cycles, SEEK_SOF, frame_cnt unchanged.
- Random m_axis_tready (50%) -> no beat lost or duplicated; data, tlast and tuser held stable while stalled.
- With HIST_EQ_CDF_TIMEOUT_EN, CDF_TIMEOUT=16 and cdf_done held 0 -> err_flags[3] set at cycle 16, no lut_swap, CLEAR entered; err_clr then returns err_flags to 0.
